// File: rtl/exhaustive_vector_sequencer.sv
// Exhaustive stimulus sequencer: walks all 2^N_IN vectors in binary or Gray order,
// samples the DUT response after a settle time, and compresses it into a MISR and a nonzero count.
module exhaustive_vector_sequencer #(
  parameter int unsigned      N_IN   = 2,
  parameter int unsigned      N_OUT  = 1,
  parameter int unsigned      SETTLE = 1,
  parameter int unsigned      SIG_W  = 16,
  parameter logic [SIG_W-1:0] POLY   = SIG_W'(16'h1021),
  parameter logic [SIG_W-1:0] SEED   = '0
) (
  input  logic              CK,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              mode,
  output logic [N_IN-1:0]   stim,
  input  logic [N_OUT-1:0]  resp,
  output logic              busy,
  output logic              done,
  output logic [SIG_W-1:0]  signature,
  output logic [N_IN:0]     nz_count,
  output logic              cap_valid,
  output logic [N_IN-1:0]   cap_vec,
  output logic [N_OUT-1:0]  cap_resp
);

  localparam int unsigned IDX_W = N_IN + 1;
  localparam int unsigned CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'((1 << N_IN) - 1);
  localparam logic [CNT_W-1:0] SAMPLE_CNT = CNT_W'(SETTLE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  logic [IDX_W-1:0]   idx;
  logic [CNT_W-1:0]   settle_cnt;
  logic               mode_q;

  logic [SIG_W-1:0]   sig_next_c;
  logic               sample_c;
  logic [IDX_W-1:0]   idx_inc_c;

  // Vector order: identity for binary, idx ^ (idx >> 1) for Gray.
  function automatic logic [N_IN-1:0] map_vec(input logic [IDX_W-1:0] i, input logic gray);
    logic [N_IN-1:0] b;
    b = i[N_IN-1:0];
    return gray ? (b ^ (b >> 1)) : b;
  endfunction

  // MISR step and sample strobe for the current vector.
  always_comb begin
    sig_next_c = (signature << 1) ^ (signature[SIG_W-1] ? POLY : '0) ^ SIG_W'(resp);
    sample_c   = (state == RUN) && !abort && (settle_cnt == SAMPLE_CNT);
    idx_inc_c  = idx + IDX_W'(1);
  end

  always_ff @(posedge CK or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      idx        <= '0;
      settle_cnt <= '0;
      mode_q     <= 1'b0;
      stim       <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      signature  <= '0;
      nz_count   <= '0;
      cap_valid  <= 1'b0;
      cap_vec    <= '0;
      cap_resp   <= '0;
    end else begin
      cap_valid <= 1'b0;
      case (state)
        IDLE, DONE: begin
          // start wins over abort here; abort has no meaning outside RUN
          if (start) begin
            state      <= RUN;
            busy       <= 1'b1;
            done       <= 1'b0;
            idx        <= '0;
            settle_cnt <= '0;
            signature  <= SEED;
            nz_count   <= '0;
            mode_q     <= mode;
            stim       <= map_vec('0, mode);
          end
        end
        RUN: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
            stim  <= '0;
          end else begin
            settle_cnt <= settle_cnt + CNT_W'(1);
            if (sample_c) begin
              signature <= sig_next_c;
              if (|resp) nz_count <= nz_count + IDX_W'(1);
              cap_valid <= 1'b1;
              cap_vec   <= stim;
              cap_resp  <= resp;
              if (idx == LAST_IDX) begin
                // last vector stays on stim for inspection
                state <= DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                idx        <= idx_inc_c;
                settle_cnt <= '0;
                stim       <= map_vec(idx_inc_c, mode_q);
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/exhaustive_vector_sequencer.md
# exhaustive_vector_sequencer

Synthesizable, parametrised successor to the fixed 2-input exhaustive stimulus bench. It walks all 2^N_IN input vectors of a combinational or sequential DUT in binary or Gray order, holds each vector for a programmable settle time, and samples the DUT response. Responses are compressed into a MISR signature and a count of vectors with a nonzero response, and each capture is streamed out for the trojan-detection logger. It sits between the stimulus side of a device under test and the capture/log path.

## Interface
- N_IN, 2: stimulus width; sequence length is 2^N_IN; legal range 1..16.
- N_OUT, 1: response width; must not exceed SIG_W.
- SETTLE, 1: cycles each vector is held before sampling; must be at least 1.
- SIG_W, 16: MISR width.
- POLY, 16'h1021: MISR feedback polynomial, SIG_W bits.
- SEED, 0: MISR value loaded at run start.

Ports:
- CK  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  begin a run; sampled in IDLE or DONE only.
- abort  in  1  terminate a run in progress.
- mode  in  1  vector order: 0 = binary ascending, 1 = Gray (idx ^ idx>>1); sampled at start.
- stim  out  N_IN  vector driven to the DUT, registered.
- resp  in  N_OUT  DUT response.
- busy  out  1  high while in RUN.
- done  out  1  high in DONE.
- signature  out  SIG_W  MISR value.
- nz_count  out  N_IN+1  number of vectors whose resp != 0.
- cap_valid  out  1  one-cycle pulse per sampled vector.
- cap_vec  out  N_IN  vector that produced cap_resp.
- cap_resp  out  N_OUT  sampled response.

## Operation
- States: IDLE, RUN, DONE.
- Reset value of every output is 0. After reset the block is in IDLE with signature = 0, not SEED.
- **IDLE:**
  - start=1 moves to RUN.
  - On that edge: idx=0, settle_cnt=0, signature=SEED, nz_count=0, stim=map(0), and mode is latched.
- **RUN:**
  - settle_cnt increments every cycle.
  - When settle_cnt==SETTLE-1, resp is sampled on that edge:
    - signature = (signature<<1) ^ (signature[SIG_W-1] ? POLY : 0) ^ zero-extend(resp).
    - nz_count is incremented if resp != 0.
    - cap_valid, cap_vec=stim and cap_resp=resp are registered for the next cycle.
  - On that same edge:
    - If idx == 2^N_IN-1, go to DONE and leave stim holding the last vector.
    - Otherwise idx++, settle_cnt=0, and stim=map(idx+1).
- **DONE:**
  - done=1 and busy=0; signature and nz_count are held.
  - start=1 begins a new run exactly as from IDLE, and done drops on that edge.
- **abort:** abort=1 in RUN returns to IDLE on the next edge.
  - stim=0 and no sample is taken on that edge.
  - signature and nz_count keep their partial values and done stays 0.
  - abort is ignored outside RUN.
- **Simultaneous events:**
  - start in RUN is ignored.
  - abort and start asserted together in RUN: abort wins.
  - start and abort asserted together in IDLE/DONE: start wins.
- idx is N_IN+1 bits wide, so the last-vector compare never wraps. nz_count cannot overflow (maximum 2^N_IN).

## Timing
- Let start be sampled at edge k.
- Vector i is visible on stim after edge k+i·SETTLE and is sampled at edge k+(i+1)·SETTLE.
- cap_valid is high in the cycle after edge k+(i+1)·SETTLE.
- done rises after edge k+2^N_IN·SETTLE. The final cap_valid coincides with the first done cycle.
- busy is high from edge k to edge k+2^N_IN·SETTLE.
- With SETTLE=1, cap_valid is continuous for 2^N_IN cycles.
- reset mid-run: all outputs go to 0 immediately, asynchronously, and the block enters IDLE. No partial result is retained.

## Test plan
- N_IN=2, SETTLE=1, mode=0, resp=stim[1]^stim[0]: stim goes 00,01,10,11 and resp goes 0,1,1,0. Required: nz_count=2, signature=16'h0006, done 4 cycles after start.
- Same setup with mode=1: stim goes 00,01,11,10 and resp goes 0,1,0,1. Required: signature=16'h0005, nz_count=2.
- N_IN=2, SETTLE=3: each stim is held 3 cycles and cap_valid pulses every third cycle. Required: done 12 cycles after start, same signature as the first case.
- N_IN=4, SETTLE=1, resp = parity of stim: 16 vectors are applied and idx stops without wrap. Required: nz_count=8, busy for exactly 16 cycles.
- Abort after 2 samples (first-case setup): IDLE on the next edge with stim=0, done=0, nz_count=1, signature=16'h0001. A start pulse during RUN is ignored.
- reset asserted mid-run and again in DONE: all outputs are 0 asynchronously, and a subsequent start reproduces the first-case results.
